// File: rtl/camera_capture_pkg.sv
// Shared geometry defaults and FSM encoding for the camera capture path,
// also used by the frame buffer and display read side.
package camera_capture_pkg;

  localparam int DEF_H_PIXELS = 320;
  localparam int DEF_V_LINES  = 240;
  localparam int DEF_ADDR_W   = 17;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2
  } cap_state_t;

  function automatic logic [15:0] rgb565(
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/camera_capture_if.sv
// Frame buffer write port plus end-of-frame status from the capture block.
interface camera_capture_if
  import camera_capture_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output frame_done,
    output frame_err
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data,
    input frame_done,
    input frame_err
  );

endinterface

// File: rtl/sync_edge_det.sv
// Registered-history edge detector; edges are flagged in the cycle the
// new level is first seen on the input.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= sig;
    end
  end

  assign rise = sig & ~q;
  assign fall = ~sig & q;

endmodule

// File: rtl/camera_capture.sv
// Sensor byte stream (vsync/href/d) to RGB565 frame buffer writes,
// with per-frame geometry error reporting.
module camera_capture
  import camera_capture_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       config_done,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] d,
  camera_capture_if.master fb
);

  localparam int COL_W  = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);

  localparam logic [COL_W-1:0]  H_MAX  = COL_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] V_MAX  = LINE_W'(V_LINES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

  cap_state_t state_q;
  cap_state_t state_d;

  logic vs_rise;
  logic vs_fall;
  logic hr_fall;
  logic hr_rise_unused;

  logic              phase;
  logic [7:0]        hi;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] addr_cnt;
  logic              pix_seen;
  logic              err;

  logic cap;
  logic start;
  logic take;
  logic fit;
  logic line_end;

  sync_edge_det u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  sync_edge_det u_hr_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (href),
    .rise (hr_rise_unused),
    .fall (hr_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (config_done) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (vs_fall) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (vs_rise) state_d = WAIT_FRAME;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!config_done) state_d = IDLE;
  end

  // Datapath only acts while configured, so a config_done drop stops writes at once.
  assign cap      = (state_q == CAPTURE) && config_done;
  assign start    = (state_q == WAIT_FRAME) && (state_d == CAPTURE);
  assign take     = cap && href && !vs_rise;
  assign line_end = cap && hr_fall && !vs_rise;
  assign fit      = (col < H_MAX) && (line < V_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase         <= 1'b0;
      hi            <= '0;
      col           <= '0;
      line          <= '0;
      line_base     <= '0;
      addr_cnt      <= '0;
      pix_seen      <= 1'b0;
      err           <= 1'b0;
      fb.wr_en      <= 1'b0;
      fb.wr_addr    <= '0;
      fb.wr_data    <= '0;
      fb.frame_done <= 1'b0;
      fb.frame_err  <= 1'b0;
    end else begin
      fb.wr_en      <= 1'b0;
      fb.frame_done <= 1'b0;
      if (start) begin
        phase        <= 1'b0;
        col          <= '0;
        line         <= '0;
        line_base    <= '0;
        addr_cnt     <= '0;
        pix_seen     <= 1'b0;
        err          <= 1'b0;
        fb.frame_err <= 1'b0;
      end else if (cap && vs_rise) begin
        fb.frame_done <= 1'b1;
        fb.frame_err  <= err || (line != V_MAX);
      end else if (take) begin
        if (!phase) begin
          hi    <= d;
          phase <= 1'b1;
        end else begin
          phase    <= 1'b0;
          pix_seen <= 1'b1;
          if (fit) begin
            fb.wr_en   <= 1'b1;
            fb.wr_data <= rgb565(hi, d);
            fb.wr_addr <= addr_cnt;
            addr_cnt   <= addr_cnt + 1'b1;
            col        <= col + 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
      end else if (line_end) begin
        phase    <= 1'b0;
        col      <= '0;
        pix_seen <= 1'b0;
        if (phase || (col < H_MAX)) err <= 1'b1;
        // Re-base from the line start so a short line cannot shift later rows.
        if (pix_seen && (line < V_MAX)) begin
          line      <= line + 1'b1;
          line_base <= line_base + H_STEP;
          addr_cnt  <= line_base + H_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Directed scoreboard bench for camera_capture with a 4x2 frame.
module tb_camera_capture;
  import camera_capture_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 8;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       config_done = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] d = '0;

  int n_chk = 0;
  int n_fail = 0;

  wr_t wq[$];
  bit  fq[$];

  camera_capture_if #(.ADDR_W(AW)) fb ();

  camera_capture #(
    .H_PIXELS (H),
    .V_LINES  (V),
    .ADDR_W   (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .config_done (config_done),
    .vsync       (vsync),
    .href        (href),
    .d           (d),
    .fb          (fb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fb.wr_en) begin
        if (wq.size() == 0) begin
          check("unexpected_write", int'(fb.wr_addr), -1);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", int'(fb.wr_addr), e.addr);
          check("wr_data", int'(fb.wr_data), e.data);
        end
      end
      if (fb.frame_done) begin
        if (fq.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          bit e;
          e = fq.pop_front();
          check("frame_err", int'(fb.frame_err), int'(e));
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    step(3);
    vsync = 1'b0;
    step(3);
  endtask

  // Sends n bytes first, first+1, ...; expects exp_n writes from base.
  task automatic send_line(input int n, input int exp_n,
                           input int base, input int first);
    for (int k = 0; k < exp_n; k++) begin
      wr_t w;
      w.addr = base + k;
      w.data = (((first + 2 * k) & 255) << 8)
             | ((first + 2 * k + 1) & 255);
      wq.push_back(w);
    end
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      d    = 8'(first + i);
      step();
    end
    href = 1'b0;
    d    = '0;
    step(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, int'(fb.wr_en), 0);
    check({tag, "_wr_addr"}, int'(fb.wr_addr), 0);
    check({tag, "_wr_data"}, int'(fb.wr_data), 0);
    check({tag, "_frame_done"}, int'(fb.frame_done), 0);
    check({tag, "_frame_err"}, int'(fb.frame_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    step(2);

    // Unconfigured: a full frame produces nothing.
    vsync_pulse();
    send_line(8, 0, 0, 8'h01);
    send_line(8, 0, 0, 8'h01);
    vsync_pulse();
    // Configured mid-frame: rest of this frame skipped.
    send_line(8, 0, 0, 8'h01);
    config_done = 1'b1;
    step(2);
    send_line(8, 0, 0, 8'h01);
    vsync_pulse();

    // Nominal frame, then two back-to-back good frames.
    send_line(8, 4, 0, 8'h01);
    send_line(8, 4, 4, 8'h01);
    fq.push_back(1'b0);
    vsync_pulse();
    send_line(8, 4, 0, 8'h11);
    send_line(8, 4, 4, 8'h21);
    fq.push_back(1'b0);
    vsync_pulse();
    send_line(8, 4, 0, 8'h91);
    send_line(8, 4, 4, 8'hA1);
    fq.push_back(1'b0);
    vsync_pulse();

    // Odd-length line: half pixel dropped, next row still at 4.
    send_line(7, 3, 0, 8'h31);
    send_line(8, 4, 4, 8'h41);
    fq.push_back(1'b1);
    vsync_pulse();

    // Over-long line and an extra line beyond V.
    send_line(10, 4, 0, 8'h51);
    send_line(8, 4, 4, 8'h61);
    send_line(8, 0, 0, 8'h71);
    fq.push_back(1'b1);
    vsync_pulse();

    // Reset mid-frame after three pixels.
    send_line(6, 3, 0, 8'h81);
    rst = 1'b1;
    step();
    check_outputs_zero("midreset");
    rst = 1'b0;
    step(3);
    send_line(8, 0, 0, 8'hC1);
    vsync_pulse();
    send_line(8, 4, 0, 8'hB1);
    send_line(8, 4, 4, 8'hB9);
    fq.push_back(1'b0);
    vsync_pulse();

    for (int i = 0; i < 50; i++) begin
      if (wq.size() == 0 && fq.size() == 0) break;
      step();
    end
    step(5);
    check("writes_pending", wq.size(), 0);
    check("frames_pending", fq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
